// File: rtl/element_pkg.sv
// Shared definitions for the pipelined element unit: op codes, FSM encoding
// and the signed saturate / round-shift helpers used by both pipeline stages.
package element_pkg;

    localparam logic [2:0] OP_PASS      = 3'd0;
    localparam logic [2:0] OP_RELU      = 3'd1;
    localparam logic [2:0] OP_BIAS      = 3'd2;
    localparam logic [2:0] OP_BIAS_RELU = 3'd3;
    localparam logic [2:0] OP_MAXPOOL   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp v to the signed range of a p-bit number (p < 64).
    function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v,
                                                   input logic [6:0] p);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (p - 7'd1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

    // Arithmetic right shift with round-half-up; operands are narrow enough
    // that the 64-bit sum never overflows.
    function automatic logic signed [63:0] round_shift_s64(input logic signed [63:0] v,
                                                           input logic [6:0] sh);
        logic signed [63:0] t;
        if (sh == 7'd0)
            return v;
        t = v + (64'sd1 <<< (sh - 7'd1));
        return t >>> sh;
    endfunction

endpackage

// File: rtl/element_lane_quant.sv
// Combinational per-lane requantiser: round-shift, saturate to the runtime
// precision, and sign-extend into the full output lane width.
module element_lane_quant
    import element_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  v,
    input  logic        [4:0]       shift,
    input  logic        [5:0]       prec,
    output logic signed [OUT_W-1:0] q
);

    // prec is already clamped to 2..OUT_W, so the saturated value fits OUT_W bits.
    assign q = OUT_W'(sat_s64(round_shift_s64(64'(v), 7'(shift)), 7'(prec)));

endmodule

// File: rtl/element_unit_pp.sv
// Pipelined element unit: streams psum vectors through a per-lane op/pool stage
// and a requantise stage, writing packed results to auto-incrementing addresses.
module element_unit_pp
    import element_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int ADDR_W   = 6,
    parameter int LEN_W    = 10,
    parameter int POOL_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               cfg_op,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [3:0]               cfg_pool,
    input  logic [IN_W-1:0]          cfg_bias,
    input  logic [4:0]               cfg_shift,
    input  logic [5:0]               cfg_out_prec,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     done
);

    state_t state_reg, state_next;

    logic [2:0]              op_reg;
    logic [LEN_W-1:0]        len_reg;
    logic [3:0]              pool_reg;
    logic signed [IN_W-1:0]  bias_reg;
    logic [4:0]              shift_reg;
    logic [5:0]              prec_reg;

    logic [LEN_W-1:0]        grp_cnt_reg;
    logic [3:0]              pool_cnt_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    s1_valid_reg;
    logic                    out_valid_reg;
    logic                    done_reg;
    logic [LANES*OUT_W-1:0]  out_data_reg;

    logic signed [IN_W-1:0]  s1_data_reg [LANES];
    logic signed [IN_W-1:0]  acc_reg     [LANES];

    logic signed [IN_W-1:0]  lane_x   [LANES];
    logic signed [IN_W-1:0]  lane_b   [LANES];
    logic signed [IN_W-1:0]  lane_r   [LANES];
    logic signed [IN_W-1:0]  lane_res [LANES];
    logic signed [OUT_W-1:0] q_lane   [LANES];
    logic [LANES*OUT_W-1:0]  out_data_next;

    logic [2:0] op_norm;
    logic [3:0] pool_norm;
    logic [5:0] prec_norm;

    logic adv, inputs_remaining, accept, group_last;
    logic is_bias, is_relu, is_pool;

    // Normalise configuration before latching so the datapath never sees
    // out-of-range op codes, pool sizes or precisions.
    always_comb begin
        op_norm = (cfg_op > OP_MAXPOOL) ? OP_PASS : cfg_op;
        pool_norm = 4'd1;
        if (op_norm == OP_MAXPOOL) begin
            if (cfg_pool == 4'd0)
                pool_norm = 4'd1;
            else if (cfg_pool > 4'(POOL_MAX))
                pool_norm = 4'(POOL_MAX);
            else
                pool_norm = cfg_pool;
        end
        if (cfg_out_prec < 6'd2)
            prec_norm = 6'd2;
        else if (cfg_out_prec > 6'(OUT_W))
            prec_norm = 6'(OUT_W);
        else
            prec_norm = cfg_out_prec;
    end

    assign is_bias = (op_reg == OP_BIAS) || (op_reg == OP_BIAS_RELU);
    assign is_relu = (op_reg == OP_RELU) || (op_reg == OP_BIAS_RELU);
    assign is_pool = (op_reg == OP_MAXPOOL);

    assign adv              = !out_valid_reg || out_ready;
    assign inputs_remaining = (grp_cnt_reg != len_reg);
    assign in_ready         = (state_reg == ST_RUN) && adv && inputs_remaining;
    assign accept           = in_valid && in_ready;
    assign group_last       = (pool_cnt_reg == pool_reg - 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_x[gi] = in_data[gi*IN_W +: IN_W];
            assign lane_b[gi] = is_bias
                ? IN_W'(sat_s64(64'(lane_x[gi]) + 64'(bias_reg), 7'(IN_W)))
                : lane_x[gi];
            assign lane_r[gi] = (is_relu && lane_b[gi] < 0) ? '0 : lane_b[gi];
            // The first vector of a group restarts the running max.
            assign lane_res[gi] = (is_pool && pool_cnt_reg != 4'd0 && acc_reg[gi] > lane_r[gi])
                ? acc_reg[gi] : lane_r[gi];

            element_lane_quant #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_quant (
                .v     (s1_data_reg[gi]),
                .shift (shift_reg),
                .prec  (prec_reg),
                .q     (q_lane[gi])
            );

            assign out_data_next[gi*OUT_W +: OUT_W] = q_lane[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (cfg_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (!inputs_remaining) state_next = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_reg && !out_valid_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_PASS;
            len_reg       <= '0;
            pool_reg      <= 4'd1;
            bias_reg      <= '0;
            shift_reg     <= '0;
            prec_reg      <= 6'(OUT_W);
            grp_cnt_reg   <= '0;
            pool_cnt_reg  <= '0;
            addr_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            out_data_reg  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_data_reg[i] <= '0;
                acc_reg[i]     <= '0;
            end
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_DONE);

            if (out_valid_reg && out_ready)
                addr_reg <= addr_reg + 1'b1;

            if (state_reg == ST_IDLE && start) begin
                op_reg       <= op_norm;
                len_reg      <= cfg_len;
                pool_reg     <= pool_norm;
                bias_reg     <= cfg_bias;
                shift_reg    <= cfg_shift;
                prec_reg     <= prec_norm;
                grp_cnt_reg  <= '0;
                pool_cnt_reg <= '0;
                addr_reg     <= cfg_base_addr;
            end

            if (accept) begin
                if (group_last) begin
                    pool_cnt_reg <= '0;
                    grp_cnt_reg  <= grp_cnt_reg + 1'b1;
                end else begin
                    pool_cnt_reg <= pool_cnt_reg + 4'd1;
                end
                for (int i = 0; i < LANES; i++)
                    acc_reg[i] <= lane_res[i];
            end

            // Both stages advance together; a stalled output freezes everything.
            if (adv) begin
                s1_valid_reg  <= accept && group_last;
                out_valid_reg <= s1_valid_reg;
                if (accept && group_last) begin
                    for (int i = 0; i < LANES; i++)
                        s1_data_reg[i] <= lane_res[i];
                end
                if (s1_valid_reg)
                    out_data_reg <= out_data_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = addr_reg;
    assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done      = done_reg;

endmodule

// File: tb/tb_element_unit_pp.sv
// Scoreboard bench for element_unit_pp: directed jobs push expected vectors,
// an independent monitor pops and compares on every output handshake.
module tb_element_unit_pp;

    localparam int LANES  = 8;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 10;

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic [ADDR_W-1:0]      addr;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [2:0]             cfg_op = '0;
    logic [LEN_W-1:0]       cfg_len = '0;
    logic [3:0]             cfg_pool = 4'd1;
    logic [IN_W-1:0]        cfg_bias = '0;
    logic [4:0]             cfg_shift = '0;
    logic [5:0]             cfg_out_prec = 6'd16;
    logic [ADDR_W-1:0]      cfg_base_addr = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [LANES*OUT_W-1:0] out_data;
    logic [ADDR_W-1:0]      out_addr;
    logic                   busy;
    logic                   done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_waits = 0;

    always #5 clk = ~clk;

    element_unit_pp #(
        .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .POOL_MAX(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_op(cfg_op), .cfg_len(cfg_len),
        .cfg_pool(cfg_pool), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
        .cfg_out_prec(cfg_out_prec), .cfg_base_addr(cfg_base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [LANES*IN_W-1:0] vec3(input int a, input int b, input int c);
        logic [LANES*IN_W-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*IN_W +: IN_W] = (i == 0) ? a : ((i == 1) ? b : c);
        return v;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] ev3(input int a, input int b, input int c);
        logic [LANES*OUT_W-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*OUT_W +: OUT_W] = (i == 0) ? OUT_W'(a) : ((i == 1) ? OUT_W'(b) : OUT_W'(c));
        return v;
    endfunction

    task automatic expect_out(input logic [LANES*OUT_W-1:0] d, input int addr);
        exp_t e;
        e.data = d;
        e.addr = ADDR_W'(addr);
        exp_q.push_back(e);
    endtask

    // Called and returns at a negedge.
    task automatic start_job(input int op, input int len, input int pool, input int bias,
                             input int shift, input int prec, input int base);
        cfg_op = 3'(op);
        cfg_len = LEN_W'(len);
        cfg_pool = 4'(pool);
        cfg_bias = IN_W'(bias);
        cfg_shift = 5'(shift);
        cfg_out_prec = 6'(prec);
        cfg_base_addr = ADDR_W'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [LANES*IN_W-1:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = v;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        last_waits = t;
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles required 1", t);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: got done=0 required 1", name);
        end
        chk({name, "_drained"}, 128'(exp_q.size()), 128'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    // Monitor: compares every output handshake and the stall-hold behaviour.
    initial begin : monitor
        logic                   stall_prev;
        logic [LANES*OUT_W-1:0] held_data;
        logic [ADDR_W-1:0]      held_addr;
        exp_t                   e;
        stall_prev = 1'b0;
        held_data = '0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", 128'(in_ready), 128'd0);
                    if (stall_prev) begin
                        chk("stall_data_hold", 128'(out_data), 128'(held_data));
                        chk("stall_addr_hold", 128'(out_addr), 128'(held_addr));
                    end
                    held_data = out_data;
                    held_addr = out_addr;
                    stall_prev = 1'b1;
                end else begin
                    stall_prev = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got data %h addr %0d required no output",
                                 out_data, out_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 128'(out_data), 128'(e.data));
                        chk("out_addr", 128'(out_addr), 128'(e.addr));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int total_waits;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_addr", 128'(out_addr), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", 128'(done), 128'd0);

        // ReLU with saturation at 16 bits
        start_job(1, 2, 1, 0, 0, 16, 5);
        chk("relu_busy", 128'(busy), 128'd1);
        expect_out(ev3(0, 7, 32767), 5);
        send_vec(vec3(-5, 7, 40000));
        expect_out(ev3(100, 0, 0), 6);
        send_vec(vec3(100, -1, -40000));
        in_valid = 1'b0;
        wait_done("relu");

        // Bias, round-shift, 8-bit saturation
        start_job(2, 1, 1, -10, 2, 8, 20);
        expect_out(ev3(23, -128, -2), 20);
        send_vec(vec3(100, -1000, 0));
        in_valid = 1'b0;
        wait_done("bias");

        start_job(3, 1, 1, -10, 2, 8, 21);
        expect_out(ev3(23, 0, 0), 21);
        send_vec(vec3(100, -1000, 0));
        in_valid = 1'b0;
        wait_done("bias_relu");

        // Maxpool over 4 vectors
        start_job(4, 1, 4, 0, 0, 16, 30);
        expect_out(ev3(12, -3, 2), 30);
        send_vec(vec3(3, -7, 0));
        send_vec(vec3(-9, -3, 1));
        send_vec(vec3(12, -20, 2));
        send_vec(vec3(5, -8, -1));
        in_valid = 1'b0;
        chk("pool_in_ready_low", 128'(in_ready), 128'd0);
        chk("pool_latency_c1", 128'(out_valid), 128'd0);
        @(negedge clk);
        chk("pool_latency_c2", 128'(out_valid), 128'd1);
        wait_done("pool");

        // Backpressure: out_ready low for 5 cycles mid-stream
        start_job(0, 8, 1, 0, 0, 16, 10);
        for (int i = 0; i < 8; i++)
            expect_out(ev3(i * 100 + 1, -i, i * 1000), 10 + i);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_vec(vec3(i * 100 + 1, -i, i * 1000));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_done("bp");

        // Address wrap, full throughput, start while busy ignored
        start_job(0, 4, 1, 0, 0, 16, 62);
        total_waits = 0;
        for (int i = 0; i < 4; i++) begin
            expect_out(ev3(-3 * (i + 1), i, -1000), 62 + i);
            if (i == 1) begin
                cfg_op = 3'd1;
                cfg_base_addr = '0;
                cfg_len = LEN_W'(1);
                start = 1'b1;
            end
            send_vec(vec3(-3 * (i + 1), i, -1000));
            start = 1'b0;
            total_waits += last_waits;
        end
        in_valid = 1'b0;
        chk("wrap_throughput_waits", 128'(total_waits), 128'd0);
        wait_done("wrap");

        // Zero-length job
        start_job(0, 0, 1, 0, 0, 16, 0);
        chk("len0_done_c1", 128'(done), 128'd0);
        @(negedge clk);
        chk("len0_done_c2", 128'(done), 128'd1);
        @(negedge clk);
        chk("len0_done_c3", 128'(done), 128'd0);

        // Reset in the middle of a job
        out_ready = 1'b0;
        start_job(0, 4, 1, 0, 0, 16, 7);
        send_vec(vec3(1, 2, 3));
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_pre_valid", 128'(out_valid), 128'd1);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'd0);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start_job(0, 1, 1, 0, 0, 16, 3);
        expect_out(ev3(11, -22, 33), 3);
        send_vec(vec3(11, -22, 33));
        in_valid = 1'b0;
        wait_done("after_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/element_unit_pp.md
Name: element_unit_pp

Overview:
- Parametrised, pipelined successor to the element unit.
- Streams partial-sum vectors out of the psum buffer and, per lane, applies an element operation: pass, ReLU, bias add, or max-pool over N vectors.
- Requantises each lane (round, shift, saturate to a programmable precision) and writes packed vectors to the element buffer at auto-incrementing addresses.
- Sits between the psum buffer read port and the element/output buffer write port; the control FSM starts it per layer.

Parameters:
- LANES, 8, number of element lanes per vector.
- IN_W, 32, signed psum lane width.
- OUT_W, 16, maximum signed output lane width.
- ADDR_W, 6, element buffer address width (depth 2**ADDR_W).
- LEN_W, 10, width of the job length counter.
- POOL_MAX, 8, maximum pool group size.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle job start; ignored unless idle.
- cfg_op  in  3  0 pass, 1 relu, 2 bias, 3 bias+relu, 4 maxpool, 5-7 treated as pass.
- cfg_len  in  LEN_W  number of output vectors in the job; 0 means finish immediately.
- cfg_pool  in  4  input vectors per output in maxpool, 1..POOL_MAX; forced to 1 for other ops.
- cfg_bias  in  IN_W  signed bias, broadcast to all lanes.
- cfg_shift  in  5  arithmetic right shift, 0..IN_W-1.
- cfg_out_prec  in  6  output precision, 2..OUT_W.
- cfg_base_addr  in  ADDR_W  first write address.
- in_valid  in  1  psum vector valid.
- in_ready  out  1  psum vector accepted when in_valid && in_ready.
- in_data  in  LANES*IN_W  psum vector; lane 0 in the LSBs.
- out_valid  out  1  element vector valid.
- out_ready  in  1  element buffer can accept.
- out_data  out  LANES*OUT_W  packed result, sign-extended per lane.
- out_addr  out  ADDR_W  write address.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the last vector is accepted.

Behaviour:
- Reset: all outputs 0, FSM IDLE, pipeline empty, counters 0.
- Configuration is latched on start; cfg_* changes mid-job have no effect.
- FSM states:
  - IDLE: on start go to RUN (cfg_len=0: go to DONE).
  - RUN: accepts inputs until cfg_len*cfg_pool vectors are consumed, then DRAIN.
  - DRAIN: waits until the pipeline is empty and the last output is accepted, then DONE.
  - DONE: asserts done for one cycle, then IDLE.
  - busy=1 in RUN and DRAIN.
- Pipeline: 2 stages, S1 = op/pool, S2 = requantise.
  - adv = !out_valid || out_ready.
  - in_ready = (state==RUN) && adv && inputs_remaining.
  - A stall freezes both stages. out_data and out_addr stay stable while out_valid && !out_ready.
- Latency: 2 cycles from acceptance of the last input of a group to out_valid, with no stall.
- Full throughput: one output per cycle with pool=1 and out_ready held high.
- S1 arithmetic, all signed, with IN_W+1 bit intermediates:
  - bias: x + cfg_bias, saturated to IN_W.
  - relu: max(x, 0).
  - maxpool: running lane-wise max, reset at each group start. Group counter counts 0..cfg_pool-1; the result is emitted on the last vector of the group.
- S2 requantise:
  - If cfg_shift>0: r = (v + 2**(cfg_shift-1)) >>> cfg_shift, with round-half-up done in IN_W+1 bits.
  - Saturate r to [-2**(P-1), 2**(P-1)-1], where P=cfg_out_prec. P is clamped to 2..OUT_W.
  - Sign-extend the result to OUT_W.
- Addressing:
  - out_addr starts at cfg_base_addr and increments on each out_valid && out_ready.
  - It wraps modulo 2**ADDR_W without error.
- start while busy: ignored; no restart, no config change.
- Reset mid-job: immediate return to IDLE; the in-flight vector is lost and no done is emitted.
- Simultaneous last-output acceptance and start (only possible from DONE/IDLE): start is accepted only in IDLE.

Decomposition:
- Package element_pkg holds:
  - op code localparams OP_PASS, OP_RELU, OP_BIAS, OP_BIAS_RELU, OP_MAXPOOL;
  - FSM state encoding;
  - saturate and round-shift functions.
- One sub-module, element_lane_quant, is natural: the combinational per-lane S2 requantiser, instantiated LANES times via generate.

Test Plan:
- Reset: assert rst during a RUN job -> in_ready, out_valid, busy, done all 0 within the same cycle; a new start works.
- relu, shift=0, prec=16, len=2, lane values -5, 7, 40000 -> outputs 0, 7, 32767 (saturated), addresses base, base+1, done pulse after the 2nd accept.
- bias=-10, shift=2, prec=8, lane value 100 -> (90+2)>>>2 = 23; lane value -1000 -> -128 (saturated).
- maxpool pool=4, len=1, lane 0 inputs 3, -9, 12, 5 -> a single output of 12 two cycles after the 4th input; in_ready is low after the 4th input.
- Backpressure: out_ready low for 5 cycles mid-stream -> out_data and out_addr stable, in_ready low, no vector lost or duplicated; throughput returns to 1/cycle.
- Address wrap: base=62, ADDR_W=6, len=4 -> addresses 62, 63, 0, 1; a start during busy has no effect; len=0 -> done 2 cycles after start with no out_valid.
